counter_ud: RTL and testbench



---
 rtl/counter_ud.sv | 71 +++++++
 tb/tb_counter_ud.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/counter_ud.sv
`default_nettype none
// ============================================================================
// Module   : counter_ud
// Purpose  : 8-bit up/down LED counter with a decade prescaler and a
//            bit-reversed mirror output.
// Revision : 1.0 - initial release
// ============================================================================
module counter_ud (
    input  logic       clk,
    input  logic       reset,
    input  logic       En,
    input  logic [2:0] SW,
    input  logic       UD,
    output logic [7:0] LED,
    output logic [7:0] Dao
);

    localparam logic [23:0] PRE_MAX_6 = 24'd9;
    localparam logic [23:0] PRE_MAX_5 = 24'd99;
    localparam logic [23:0] PRE_MAX_4 = 24'd999;
    localparam logic [23:0] PRE_MAX_3 = 24'd9999;
    localparam logic [23:0] PRE_MAX_2 = 24'd99999;
    localparam logic [23:0] PRE_MAX_1 = 24'd999999;
    localparam logic [23:0] PRE_MAX_0 = 24'd9999999;

    logic [7:0]  cnt;
    logic [23:0] pre;
    logic [23:0] pre_max;
    logic        tick;

    always_comb begin
        pre_max = 24'd0;
        case (SW)
            3'd6:    pre_max = PRE_MAX_6;
            3'd5:    pre_max = PRE_MAX_5;
            3'd4:    pre_max = PRE_MAX_4;
            3'd3:    pre_max = PRE_MAX_3;
            3'd2:    pre_max = PRE_MAX_2;
            3'd1:    pre_max = PRE_MAX_1;
            3'd0:    pre_max = PRE_MAX_0;
            default: pre_max = 24'd0;
        endcase
    end

    // >= rather than == so a shrinking period never strands pre above the limit
    assign tick = En && (pre >= pre_max);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 8'd0;
            pre <= 24'd0;
        end else if (En) begin
            if (tick) begin
                pre <= 24'd0;
                cnt <= UD ? (cnt - 8'd1) : (cnt + 8'd1);
            end else begin
                pre <= pre + 24'd1;
            end
        end
    end

    assign LED = cnt;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_rev
            assign Dao[i] = cnt[7-i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_counter_ud.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_ud
// Purpose  : Directed self-checking bench for counter_ud.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_ud;

    logic       clk;
    logic       reset;
    logic       En;
    logic [2:0] SW;
    logic       UD;
    logic [7:0] LED;
    logic [7:0] Dao;

    int tests_run;
    int tests_failed;

    counter_ud dut (
        .clk   (clk),
        .reset (reset),
        .En    (En),
        .SW    (SW),
        .UD    (UD),
        .LED   (LED),
        .Dao   (Dao)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [7:0] exp);
        check({tag, "_led"}, LED, exp);
        check({tag, "_dao"}, Dao, rev8(exp));
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        En    = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    task automatic run_decade(input logic [2:0] sw, input int p);
        do_reset();
        SW = sw;
        UD = 1'b0;
        En = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(p - 1);
            check("dec_before", LED, 8'(k - 1));
            step(1);
            check("dec_tick", LED, 8'(k));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0;
        En    = 1'b1;
        SW    = 3'd7;
        UD    = 1'b0;

        // Reset holds state even with En=1 across clock edges
        step(3);
        check_both("reset", 8'h00);

        reset = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            step(1);
            check_both("up", 8'(n));
        end
        check_both("up_end", 8'h2C);

        En = 1'b0;
        step(150);
        check_both("hold", 8'h2C);

        // Pause in the middle of a 10-cycle period; the phase must survive
        SW = 3'd6;
        En = 1'b1;
        step(4);
        check("mid_pre4", LED, 8'h2C);
        En = 1'b0;
        step(20);
        check("mid_hold", LED, 8'h2C);
        En = 1'b1;
        step(5);
        check("mid_resume5", LED, 8'h2C);
        step(1);
        check_both("mid_resume6", 8'h2D);

        do_reset();
        SW = 3'd7;
        UD = 1'b1;
        En = 1'b1;
        step(1);
        check_both("down1", 8'hFF);
        check("down1_dao", Dao, 8'hFF);
        step(1);
        check_both("down2", 8'hFE);
        check("down2_dao", Dao, 8'h7F);

        run_decade(3'd6, 10);
        run_decade(3'd5, 100);
        run_decade(3'd4, 1000);

        do_reset();
        SW = 3'd4;
        UD = 1'b0;
        En = 1'b1;
        step(500);
        check("shrink_pre", LED, 8'h00);
        SW = 3'd6;
        step(1);
        check("shrink_tick", LED, 8'h01);
        step(9);
        check("shrink_before", LED, 8'h01);
        step(1);
        check("shrink_next", LED, 8'h02);
        step(10);
        check("shrink_next2", LED, 8'h03);

        do_reset();
        SW = 3'd7;
        UD = 1'b0;
        En = 1'b1;
        step(55);
        check_both("pre_async", 8'h37);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_both("async_rst", 8'h00);
        step(2);
        check_both("async_hold", 8'h00);
        reset = 1'b1;
        step(1);
        check_both("async_resume1", 8'h01);
        step(1);
        check_both("async_resume2", 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
